pzcorebus_write_order_gate: RTL



---
 rtl/pzcorebus_pkg.sv | 17 +
 rtl/pzcorebus_write_order_gate_queue.sv | 53 +++++
 rtl/pzcorebus_write_order_gate.sv | 105 ++++++++++
 3 files changed

// File: rtl/pzcorebus_pkg.sv
// Shared types and helpers for the corebus write-order gate.
package pzcorebus_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } data_state_e;

  // An encoded length of zero stands for the longest burst the bus allows.
  function automatic int unsigned decode_burst_length(
    input int unsigned length,
    input int unsigned max_length
  );
    return (length == 0) ? max_length : length;
  endfunction

endpackage

// File: rtl/pzcorebus_write_order_gate_queue.sv
// Burst-length FIFO holding one entry per accepted write command whose data is incomplete.
module pzcorebus_write_order_gate_queue
  import pzcorebus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pzcorebus_write_order_gate.sv
// Corebus write-order gate: holds write data until its command is accepted.
// Optional zero-latency bypass when PZCOREBUS_WRITE_ORDER_GATE_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | no write command awaiting data
// BURST | head burst in progress, beat_count beats already passed
module pzcorebus_write_order_gate
  import pzcorebus_pkg::*;
#(
  parameter int MAX_BURST_LENGTH = 256,
  parameter int DEPTH            = 4,
  parameter int BL_WIDTH         = $clog2(MAX_BURST_LENGTH + 1),
  localparam int PEND_W          = $clog2(DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_mcmd_valid,
  input  logic                i_mcmd_with_data,
  input  logic [BL_WIDTH-1:0] i_mburst_length,
  output logic                o_scmd_accept,
  output logic                o_mcmd_valid,
  input  logic                i_scmd_accept,
  input  logic                i_mdata_valid,
  input  logic                i_mdata_last,
  output logic                o_sdata_accept,
  output logic                o_mdata_valid,
  input  logic                i_sdata_accept,
  output logic [PEND_W-1:0]   o_pending,
  output logic                o_error,
  output logic                o_error_sticky
);

  data_state_e         state;
  logic [BL_WIDTH-1:0] beat_count;
  logic [BL_WIDTH-1:0] cmd_length;
  logic [BL_WIDTH-1:0] queue_head;
  logic [BL_WIDTH-1:0] head_length;
  logic                full;
  logic                empty;
  logic                cmd_block;
  logic                cmd_push;
  logic                bypass;
  logic                data_open;
  logic                data_ack;
  logic                burst_end;
  logic                push;
  logic                pop;

  assign cmd_block     = i_mcmd_with_data && full;
  assign o_mcmd_valid  = i_mcmd_valid && !cmd_block;
  assign o_scmd_accept = i_scmd_accept && !cmd_block;
  assign cmd_push      = o_mcmd_valid && i_scmd_accept && i_mcmd_with_data;
  assign cmd_length    = BL_WIDTH'(decode_burst_length(32'(i_mburst_length), MAX_BURST_LENGTH));

`ifdef PZCOREBUS_WRITE_ORDER_GATE_BYPASS_EN
  assign bypass = empty && cmd_push;
`else
  assign bypass = 1'b0;
`endif

  assign head_length    = bypass ? cmd_length : queue_head;
  assign data_open      = !empty || bypass;
  assign o_mdata_valid  = i_mdata_valid && data_open;
  assign o_sdata_accept = i_sdata_accept && data_open;
  assign data_ack       = o_mdata_valid && i_sdata_accept;
  assign burst_end      = (beat_count + BL_WIDTH'(1)) == head_length;

  // A burst finishing in its own bypass cycle never needs a queue entry.
  assign pop  = data_ack && burst_end && !bypass;
  assign push = cmd_push && !(bypass && data_ack && burst_end);

  pzcorebus_write_order_gate_queue #(
    .DEPTH (DEPTH),
    .WIDTH (BL_WIDTH)
  ) u_queue (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (cmd_length),
    .pop       (pop),
    .head      (queue_head),
    .full      (full),
    .empty     (empty),
    .count     (o_pending)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      beat_count     <= '0;
      o_error        <= 1'b0;
      o_error_sticky <= 1'b0;
    end else begin
      o_error <= data_ack && (i_mdata_last != burst_end);
      if (data_ack && (i_mdata_last != burst_end)) o_error_sticky <= 1'b1;
      if (data_ack) beat_count <= burst_end ? '0 : beat_count + BL_WIDTH'(1);
      case (state)
        IDLE:    if (push) state <= BURST;
        BURST:   if (pop && !push && (o_pending == PEND_W'(1))) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
